// File: rtl/top.sv
// FT2232H async-FIFO to three-wire bridge with heartbeat LED.
// Optional feature macro: ECHO_CMD_EN (0xAA echoes the next host byte).
//
// Decoder states:
//   state       | meaning
//   IDLE        | waiting for a command byte
//   GET_ADDR_HI | waiting for address byte (bit 0 = address bit 8)
//   GET_ADDR_LO | waiting for address bits 7:0
//   GET_DATA_HI | waiting for write data bits 15:8
//   GET_DATA_LO | waiting for write data bits 7:0
//   GET_ECHO    | waiting for the byte to echo
//   TW_XFER     | three-wire frame in progress
//   SEND_HI     | returning read data bits 15:8
//   SEND_LO     | returning last (or only) reply byte
module top #(
    parameter int TW_HALF_DIV = 4,
    parameter int FT_STROBE   = 3,
    parameter int LED_BITS    = 25
) (
    input  logic       in_ext_osc,
    input  logic       in_reset_n,
    inout  wire  [7:0] io_ftdi_data,
    input  logic       in_ftdi_rxf_n,
    input  logic       in_ftdi_txe_n,
    output logic       out_ftdi_rd_n,
    output logic       out_ftdi_wr_n,
    output logic       out_tw_clock,
    output logic       out_tw_cs,
    inout  wire        io_tw_data,
    output logic       out_led
);

    localparam logic [7:0]  STROBE_LAST = 8'(FT_STROBE - 1);
    localparam logic [7:0]  GAP_LAST    = 8'd3;
    localparam logic [15:0] HALF_LAST   = 16'(TW_HALF_DIV - 1);

    typedef enum logic [2:0] {FT_IDLE, FT_RD, FT_WR_SU, FT_WR, FT_WR_HOLD, FT_GAP} ft_state_t;
    typedef enum logic [3:0] {IDLE, GET_ADDR_HI, GET_ADDR_LO, GET_DATA_HI, GET_DATA_LO,
                              GET_ECHO, TW_XFER, SEND_HI, SEND_LO} dec_state_t;
    typedef enum logic [1:0] {TW_IDLE, TW_RUN, TW_TAIL} tw_state_t;

    ft_state_t  ft_state;
    dec_state_t dec_state;
    tw_state_t  tw_state;

    logic [7:0]  ft_cnt, ft_dout, rx_byte, tx_byte;
    logic        ft_oe, rx_valid, tx_done;
    logic        is_wr, tw_start, tw_done, tw_is_wr, tw_oe;
    logic [8:0]  addr;
    logic [15:0] wdata, tw_rdata, hcnt;
    logic [5:0]  stp;
    logic [25:0] sreg;
    logic [4:0]  n_pulses;
    logic [LED_BITS-1:0] led_cnt;
    logic        rx_want, tx_req;

    assign rx_want  = (dec_state == IDLE) || (dec_state == GET_ADDR_HI) || (dec_state == GET_ADDR_LO)
                   || (dec_state == GET_DATA_HI) || (dec_state == GET_DATA_LO) || (dec_state == GET_ECHO);
    assign tx_req   = (dec_state == SEND_HI) || (dec_state == SEND_LO);
    assign n_pulses = tw_is_wr ? 5'd26 : 5'd27;

    assign io_ftdi_data = ft_oe ? ft_dout : 8'hzz;
    assign io_tw_data   = tw_oe ? sreg[25] : 1'bz;
    assign out_led      = led_cnt[LED_BITS-1];

    // FIFO bus engine: one read or write strobe at a time, then a 4-cycle guard gap
    always_ff @(posedge in_ext_osc or negedge in_reset_n) begin
        if (!in_reset_n) begin
            ft_state      <= FT_IDLE;
            ft_cnt        <= '0;
            ft_oe         <= 1'b0;
            ft_dout       <= '0;
            rx_byte       <= '0;
            rx_valid      <= 1'b0;
            tx_done       <= 1'b0;
            out_ftdi_rd_n <= 1'b1;
            out_ftdi_wr_n <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
            case (ft_state)
                FT_IDLE: begin
                    if (tx_req && !in_ftdi_txe_n) begin
                        ft_oe    <= 1'b1;
                        ft_dout  <= tx_byte;
                        ft_state <= FT_WR_SU;
                    end else if (rx_want && !in_ftdi_rxf_n) begin
                        out_ftdi_rd_n <= 1'b0;
                        ft_cnt        <= STROBE_LAST;
                        ft_state      <= FT_RD;
                    end
                end
                FT_RD: begin
                    if (ft_cnt == 8'd0) begin
                        rx_byte       <= io_ftdi_data;
                        rx_valid      <= 1'b1;
                        out_ftdi_rd_n <= 1'b1;
                        ft_cnt        <= GAP_LAST;
                        ft_state      <= FT_GAP;
                    end else begin
                        ft_cnt <= ft_cnt - 8'd1;
                    end
                end
                FT_WR_SU: begin
                    out_ftdi_wr_n <= 1'b0;
                    ft_cnt        <= STROBE_LAST;
                    ft_state      <= FT_WR;
                end
                FT_WR: begin
                    if (ft_cnt == 8'd0) begin
                        out_ftdi_wr_n <= 1'b1;
                        ft_state      <= FT_WR_HOLD;
                    end else begin
                        ft_cnt <= ft_cnt - 8'd1;
                    end
                end
                FT_WR_HOLD: begin
                    ft_oe    <= 1'b0;
                    tx_done  <= 1'b1;
                    ft_cnt   <= GAP_LAST;
                    ft_state <= FT_GAP;
                end
                FT_GAP: begin
                    if (ft_cnt == 8'd0) ft_state <= FT_IDLE;
                    else                ft_cnt   <= ft_cnt - 8'd1;
                end
                default: ft_state <= FT_IDLE;
            endcase
        end
    end

    // Command decoder: collects command bytes, launches frames, queues replies
    always_ff @(posedge in_ext_osc or negedge in_reset_n) begin
        if (!in_reset_n) begin
            dec_state <= IDLE;
            is_wr     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            tx_byte   <= '0;
            tw_start  <= 1'b0;
        end else begin
            tw_start <= 1'b0;
            case (dec_state)
                IDLE: if (rx_valid) begin
                    case (rx_byte)
                        8'h00: begin is_wr <= 1'b0; dec_state <= GET_ADDR_HI; end
                        8'h01: begin is_wr <= 1'b1; dec_state <= GET_ADDR_HI; end
                        8'hFF: begin tx_byte <= 8'hFF; dec_state <= SEND_LO; end
`ifdef ECHO_CMD_EN
                        8'hAA: dec_state <= GET_ECHO;
`endif
                        default: begin tx_byte <= 8'hEE; dec_state <= SEND_LO; end
                    endcase
                end
                GET_ADDR_HI: if (rx_valid) begin
                    addr[8]   <= rx_byte[0];
                    dec_state <= GET_ADDR_LO;
                end
                GET_ADDR_LO: if (rx_valid) begin
                    addr[7:0] <= rx_byte;
                    if (is_wr) begin
                        dec_state <= GET_DATA_HI;
                    end else begin
                        tw_start  <= 1'b1;
                        dec_state <= TW_XFER;
                    end
                end
                GET_DATA_HI: if (rx_valid) begin
                    wdata[15:8] <= rx_byte;
                    dec_state   <= GET_DATA_LO;
                end
                GET_DATA_LO: if (rx_valid) begin
                    wdata[7:0] <= rx_byte;
                    tw_start   <= 1'b1;
                    dec_state  <= TW_XFER;
                end
`ifdef ECHO_CMD_EN
                GET_ECHO: if (rx_valid) begin
                    tx_byte   <= rx_byte;
                    dec_state <= SEND_LO;
                end
`endif
                TW_XFER: if (tw_done) begin
                    if (is_wr) begin
                        tx_byte   <= 8'h01;
                        dec_state <= SEND_LO;
                    end else begin
                        tx_byte   <= tw_rdata[15:8];
                        dec_state <= SEND_HI;
                    end
                end
                SEND_HI: if (tx_done) begin
                    tx_byte   <= tw_rdata[7:0];
                    dec_state <= SEND_LO;
                end
                SEND_LO: if (tx_done) dec_state <= IDLE;
                default: dec_state <= IDLE;
            endcase
        end
    end

    // Three-wire master: stp counts half-periods; even ticks raise the clock, odd ticks lower it
    always_ff @(posedge in_ext_osc or negedge in_reset_n) begin
        if (!in_reset_n) begin
            tw_state     <= TW_IDLE;
            hcnt         <= '0;
            stp          <= '0;
            sreg         <= '0;
            tw_oe        <= 1'b0;
            tw_is_wr     <= 1'b0;
            tw_rdata     <= '0;
            tw_done      <= 1'b0;
            out_tw_clock <= 1'b0;
            out_tw_cs    <= 1'b0;
        end else begin
            tw_done <= 1'b0;
            case (tw_state)
                TW_IDLE: if (tw_start) begin
                    out_tw_cs <= 1'b1;
                    tw_oe     <= 1'b1;
                    sreg      <= {is_wr, addr, wdata};
                    tw_is_wr  <= is_wr;
                    stp       <= '0;
                    hcnt      <= HALF_LAST;
                    tw_state  <= TW_RUN;
                end
                TW_RUN: begin
                    if (hcnt != 16'd0) begin
                        hcnt <= hcnt - 16'd1;
                    end else begin
                        hcnt <= HALF_LAST;
                        stp  <= stp + 6'd1;
                        if (!stp[0]) begin
                            if (stp[5:1] == n_pulses) begin
                                out_tw_cs <= 1'b0;
                                tw_oe     <= 1'b0;
                                stp       <= '0;
                                tw_state  <= TW_TAIL;
                            end else begin
                                out_tw_clock <= 1'b1;
                                if (!tw_is_wr && stp[5:1] >= 5'd11)
                                    tw_rdata <= {tw_rdata[14:0], io_tw_data};
                            end
                        end else begin
                            out_tw_clock <= 1'b0;
                            sreg         <= {sreg[24:0], 1'b0};
                            // reads release the line after address bit 0 for the turnaround
                            if (stp[5:1] == (tw_is_wr ? 5'd25 : 5'd9))
                                tw_oe <= 1'b0;
                        end
                    end
                end
                TW_TAIL: begin
                    if (hcnt != 16'd0) begin
                        hcnt <= hcnt - 16'd1;
                    end else begin
                        hcnt <= HALF_LAST;
                        if (stp[0]) begin
                            tw_done  <= 1'b1;
                            tw_state <= TW_IDLE;
                        end else begin
                            stp <= stp + 6'd1;
                        end
                    end
                end
                default: tw_state <= TW_IDLE;
            endcase
        end
    end

    // Free-running heartbeat counter
    always_ff @(posedge in_ext_osc or negedge in_reset_n) begin
        if (!in_reset_n) led_cnt <= '0;
        else             led_cnt <= led_cnt + 1'b1;
    end

endmodule

// File: tb/tb_top.sv
// Directed bench for top: FT2232H host model, three-wire slave model, reply scoreboard.
module tb_top;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxf_n = 1'b1;
    logic       txe_n = 1'b0;
    logic       rd_n, wr_n, tw_clk, tw_cs, led;
    wire  [7:0] ftdi_data;
    wire        tw_data;

    logic [7:0] host_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] host_drv = 8'h00;

    int total = 0;
    int bad   = 0;

    logic [15:0] slave_rd = 16'h0000;
    logic        sl_oe = 1'b0, sl_bit = 1'b0;
    logic        bl [0:31];
    int          tw_pulses = 0, frames = 0, f_pulses = 0, first_gap = 0;
    logic        f_rw = 1'b0;
    logic [8:0]  f_addr = '0;
    logic [15:0] f_data = '0;
    realtime     t_cs = 0, t_rd = 0, t_wr = 0;
    int          rd_w = 0, wr_w = 0;
    logic [7:0]  wr_setup = 8'h00;
    logic        overlap = 1'b0;

    always #5 clk = ~clk;

    top #(.TW_HALF_DIV(4), .FT_STROBE(3), .LED_BITS(4)) dut (
        .in_ext_osc   (clk),
        .in_reset_n   (rst_n),
        .io_ftdi_data (ftdi_data),
        .in_ftdi_rxf_n(rxf_n),
        .in_ftdi_txe_n(txe_n),
        .out_ftdi_rd_n(rd_n),
        .out_ftdi_wr_n(wr_n),
        .out_tw_clock (tw_clk),
        .out_tw_cs    (tw_cs),
        .io_tw_data   (tw_data),
        .out_led      (led)
    );

    assign ftdi_data = (rd_n === 1'b0) ? host_drv : 8'hzz;
    assign tw_data   = sl_oe ? sl_bit : 1'bz;
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (ftdi_data[gi]);
    end
    pullup (tw_data);

    // host side of the FIFO
    initial forever begin
        @(negedge clk);
        rxf_n    = (host_q.size() == 0);
        host_drv = (host_q.size() != 0) ? host_q[0] : 8'h00;
        if (rd_n === 1'b0 && wr_n === 1'b0) overlap = 1'b1;
    end
    initial forever begin
        @(negedge rd_n);
        t_rd = $realtime;
    end
    initial forever begin
        @(posedge rd_n);
        if (rst_n) begin
            rd_w = int'(($realtime - t_rd) / 10.0);
            if (host_q.size() != 0) void'(host_q.pop_front());
        end
    end
    initial forever begin
        @(negedge wr_n);
        t_wr     = $realtime;
        wr_setup = ftdi_data;
    end
    initial forever begin
        @(posedge wr_n);
        if (rst_n) begin
            wr_w = int'(($realtime - t_wr) / 10.0);
            got_q.push_back(ftdi_data);
        end
    end

    // three-wire slave
    initial forever begin
        @(posedge tw_cs);
        t_cs      = $realtime;
        tw_pulses = 0;
    end
    initial forever begin
        @(posedge tw_clk);
        if (tw_cs) begin
            if (tw_pulses == 0) first_gap = int'($realtime - t_cs);
            if (tw_pulses < 32) bl[tw_pulses] = tw_data;
            tw_pulses++;
        end
    end
    initial forever begin
        @(negedge tw_clk);
        if (tw_cs && bl[0] === 1'b0 && tw_pulses >= 11 && tw_pulses <= 26) begin
            sl_oe  = 1'b1;
            sl_bit = slave_rd[26 - tw_pulses];
        end else begin
            sl_oe = 1'b0;
        end
    end
    initial forever begin
        @(negedge tw_cs);
        frames++;
        f_pulses = tw_pulses;
        f_rw     = bl[0];
        for (int i = 1; i <= 9; i++)   f_addr = {f_addr[7:0], bl[i]};
        for (int i = 10; i <= 25; i++) f_data = {f_data[14:0], bl[i]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        host_q.push_back(b);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        logic [7:0] e, g;
        while (got_q.size() < exp_q.size() && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (40) @(posedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() != 0) ? got_q.pop_front() : 8'hxx;
            chk(tag, {24'h0, g}, {24'h0, e});
        end
        got_q.delete();
    endtask

    initial begin
        int f0;
        int n;
        #23;
        chk("rst_rd_n", rd_n, 1'b1);
        chk("rst_wr_n", wr_n, 1'b1);
        chk("rst_ftdi_z", ftdi_data, 8'hFF);
        chk("rst_tw_clk", tw_clk, 1'b0);
        chk("rst_tw_cs", tw_cs, 1'b0);
        chk("rst_tw_z", tw_data, 1'b1);
        chk("rst_led", led, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("led_lo", led, 1'b0);
        @(posedge clk);
        #1 chk("led_hi", led, 1'b1);

        // READ 0x1BB
        slave_rd = 16'hAABB;
        f0 = frames;
        send(8'h00); send(8'h01); send(8'hBB);
        expect_byte(8'hAA); expect_byte(8'hBB);
        drain("read1");
        chk("read1_frames", frames - f0, 1);
        chk("read1_rw", f_rw, 1'b0);
        chk("read1_addr", f_addr, 9'h1BB);
        chk("read1_pulses", f_pulses, 27);
        chk("cs_to_first_rise", first_gap, 40);
        chk("rd_strobe_width", rd_w, 3);
        chk("wr_strobe_width", wr_w, 3);

        // READ with junk in addr_hi bits 7:1
        slave_rd = 16'h1234;
        send(8'h00); send(8'hFE); send(8'h34);
        expect_byte(8'h12); expect_byte(8'h34);
        drain("read2");
        chk("read2_addr", f_addr, 9'h034);

        // WRITE 0xCCDD to 0x1BB
        f0 = frames;
        send(8'h01); send(8'h01); send(8'hBB); send(8'hCC); send(8'hDD);
        expect_byte(8'h01);
        drain("write");
        chk("write_frames", frames - f0, 1);
        chk("write_rw", f_rw, 1'b1);
        chk("write_addr", f_addr, 9'h1BB);
        chk("write_data", f_data, 16'hCCDD);
        chk("write_pulses", f_pulses, 26);
        chk("wr_data_setup", wr_setup, 8'h01);

        // PING, held off by txe_n
        f0 = frames;
        txe_n = 1'b1;
        send(8'hFF);
        repeat (300) @(posedge clk);
        chk("ping_stalled", got_q.size(), 0);
        txe_n = 1'b0;
        expect_byte(8'hFF);
        drain("ping");
        chk("ping_no_tw", frames - f0, 0);

        // ECHO
        send(8'hAA); send(8'hF1);
`ifdef ECHO_CMD_EN
        expect_byte(8'hF1);
`else
        expect_byte(8'hEE); expect_byte(8'hEE);
`endif
        drain("echo");

        // unknown command, then confirm the decoder is idle
        send(8'h7E);
        expect_byte(8'hEE);
        drain("unknown");
        send(8'hFF);
        expect_byte(8'hFF);
        drain("ping_after_unknown");
        chk("ftdi_idle_z", ftdi_data, 8'hFF);

        // reset mid write frame while the master drives zero data
        send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        n = 0;
        while (!tw_cs && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("midrst_frame_started", tw_cs, 1'b1);
        repeat (120) @(posedge clk);
        chk("midrst_master_drives", tw_data, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs", tw_cs, 1'b0);
        chk("midrst_tw_z", tw_data, 1'b1);
        chk("midrst_tw_clk", tw_clk, 1'b0);
        chk("midrst_wr_n", wr_n, 1'b1);
        chk("midrst_ftdi_z", ftdi_data, 8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(posedge clk);
        chk("midrst_no_reply", got_q.size(), 0);
        send(8'hFF);
        expect_byte(8'hFF);
        drain("ping_after_reset");

        chk("strobe_overlap", overlap, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Clock and reset SHALL be one clock, in_ext_osc; reset in_reset_n SHALL be asynchronous and active-low.
REQ-002 Parameter TW_HALF_DIV, default 4: in_ext_osc cycles per out_tw_clock half-period.
REQ-003 Parameter FT_STROBE, default 3: in_ext_osc cycles that out_ftdi_rd_n/out_ftdi_wr_n stay low per strobe.
REQ-004 Parameter LED_BITS, default 25: heartbeat counter width.
REQ-005 in_ext_osc  in  1  system clock, 66 MHz nominal.
REQ-006 in_reset_n  in  1  async active-low reset.
REQ-007 io_ftdi_data  inout  8  FT2232H async-FIFO data bus.
REQ-008 in_ftdi_rxf_n  in  1  low = host byte available.
REQ-009 in_ftdi_txe_n  in  1  low = FT2232H can accept a byte.
REQ-010 out_ftdi_rd_n / out_ftdi_wr_n  out  1 each  active-low read / write strobes.
REQ-011 out_tw_clock  out  1  three-wire clock, idles low.
REQ-012 out_tw_cs  out  1  three-wire chip select, active-high.
REQ-013 io_tw_data  inout  1  three-wire bidirectional data.
REQ-014 out_led  out  1  heartbeat LED.

Function
REQ-015 The FIFO reader SHALL start a read only when in_ftdi_rxf_n is low in the same cycle.
- Read sequence: drive out_ftdi_rd_n low for FT_STROBE cycles; sample io_ftdi_data in the last low cycle; drive rd_n high; ignore rxf_n for the next 4 cycles.
REQ-016 The FIFO writer SHALL start a write only when in_ftdi_txe_n is low in the same cycle.
- Drive io_ftdi_data 1 cycle before out_ftdi_wr_n falls.
- Hold wr_n low for FT_STROBE cycles.
- Hold data 1 cycle after wr_n rises, then tri-state it.
- Ignore txe_n for the next 4 cycles.
REQ-017 io_ftdi_data SHALL be high-Z except during a write; rd_n and wr_n SHALL never be low together.
REQ-018 Command decoder states: IDLE, GET_ADDR_HI, GET_ADDR_LO, GET_DATA_HI, GET_DATA_LO, GET_ECHO, TW_XFER, SEND_HI, SEND_LO.
REQ-019 0x00 READ: receive addr_hi (bit 0 = address bit 8; bits 7:1 ignored) and addr_lo; run a three-wire read; send data[15:8] then data[7:0].
REQ-020 0x01 WRITE: receive addr_hi, addr_lo, data_hi, data_lo; run a three-wire write; after the frame ends, send one byte 0x01.
REQ-021 0xFF PING: send one byte 0xFF.
REQ-022 0xAA ECHO: receive one byte; send it back unchanged.
REQ-023 Any other command byte SHALL produce one reply byte 0xEE and return to IDLE; only the command byte is consumed.
REQ-024 The decoder SHALL wait indefinitely mid-command for host bytes or txe_n; there is no timeout.
REQ-025 Three-wire frame:
- out_tw_cs rises one half-period before the first clock rise.
- Master changes io_tw_data while out_tw_clock is low; bits are sampled on the rising edge.
- Bit order: R/W bit first (1 = write, 0 = read), then address[8:0] MSB first.
REQ-026 Three-wire write: 16 data bits MSB first follow the address; the frame is 26 clock pulses.
REQ-027 Three-wire read: the master tri-states io_tw_data after address bit 0.
- One turnaround clock pulse follows.
- The master then samples 16 slave bits MSB first on rising edges; the frame is 27 clock pulses.
REQ-028 After the last pulse, out_tw_clock SHALL return low, then out_tw_cs SHALL fall after one half-period; the next frame starts no earlier than 2 half-periods later.
REQ-029 out_led SHALL equal bit LED_BITS-1 of a free-running counter.

Reset
REQ-030 While in_reset_n is low, all outputs SHALL take their reset values:
- out_ftdi_rd_n = 1, out_ftdi_wr_n = 1, io_ftdi_data = Z.
- out_tw_clock = 0, out_tw_cs = 0, io_tw_data = Z.
- out_led = 0, decoder in IDLE, all counters 0.
REQ-031 A reset asserted mid-command or mid-frame SHALL abort immediately with no further strobes or bus activity; operation resumes from IDLE after release.

Configuration
REQ-032 Macro ECHO_CMD_EN:
- Defined: 0xAA is the ECHO command.
- Undefined: the ECHO logic is absent and 0xAA is an unknown command (reply 0xEE); the following byte is then decoded as a new command.

Verification
REQ-033 Host sends 00 01 BB with slave read data 0xAABB -> slave sees read frame with address 0x1BB; host receives AA, BB.
REQ-034 Host sends 01 01 BB CC DD -> slave sees write of 0xCCDD to 0x1BB in a 26-pulse frame; host receives 01.
REQ-035 Host sends FF -> host receives FF and there is no three-wire activity.
REQ-036 Host sends AA F1 -> host receives F1 with ECHO_CMD_EN defined; host receives EE, EE with it undefined.
REQ-037 Host sends 7E -> host receives EE; decoder back in IDLE.
REQ-038 Reset pulsed mid write frame -> out_tw_cs = 0 and io_tw_data = Z at once; a following PING is answered with FF.
